// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Iteration counter width: ceil(log2(n)), never below one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the serial adder chains these into one slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + cin summed BITS_PER_CYCLE bits per clock through a
// ripple slice of full_adder cells, carry held in a register between slices.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             busy
);

   localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CW = cnt_w(N);

   // Configuration guard: the slice must tile the operand exactly.
   if (BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
   end

   state_e                    r_state;
   logic [CW-1:0]             r_cnt;
   logic [WIDTH-1:0]          r_a_q;
   logic [WIDTH-1:0]          r_b_q;
   logic                      r_carry_q;
   logic [WIDTH-1:0]          r_sum;
   logic                      r_carry;
   logic                      r_out_valid;
   logic                      r_in_ready;
   logic                      r_busy;

   logic [BITS_PER_CYCLE:0]   w_c;
   logic [BITS_PER_CYCLE-1:0] w_slice_sum;
   logic [WIDTH-1:0]          w_sum_next;

   // Ripple slice over the low bits of the operand shift registers.
   assign w_c[0] = r_carry_q;
   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
      full_adder u_fa (
         .a     (r_a_q[i]),
         .b     (r_b_q[i]),
         .cin   (w_c[i]),
         .sum   (w_slice_sum[i]),
         .carry (w_c[i+1])
      );
   end

   // Slice result enters at the MSB end while the sum register shifts right.
   if (WIDTH == BITS_PER_CYCLE) begin : g_sum_full
      assign w_sum_next = w_slice_sum;
   end else begin : g_sum_shift
      assign w_sum_next = {w_slice_sum, r_sum[WIDTH-1:BITS_PER_CYCLE]};
   end

   // FSM, iteration counter and shift registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_a_q       <= '0;
         r_b_q       <= '0;
         r_carry_q   <= 1'b0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (in_valid && r_in_ready) begin
                  r_a_q      <= a;
                  r_b_q      <= b;
                  r_carry_q  <= cin;
                  r_cnt      <= '0;
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            RUN: begin
               r_sum     <= w_sum_next;
               r_carry   <= w_c[BITS_PER_CYCLE];
               r_carry_q <= w_c[BITS_PER_CYCLE];
               r_a_q     <= r_a_q >> BITS_PER_CYCLE;
               r_b_q     <= r_b_q >> BITS_PER_CYCLE;
               // Hold the counter on the last slice so it never wraps.
               if (r_cnt == CW'(N - 1)) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign carry     = r_carry;
   assign busy      = r_busy;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at W=8/B=1 and W=16/B=4.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 8-bit, one bit per cycle
   logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, carry8, busy8;
   logic [7:0] a8, b8, sum8;
   // 16-bit, four bits per cycle
   logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, carry16, busy16;
   logic [15:0] a16, b16, sum16;

   serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .carry(carry8), .busy(busy8));

   serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
      .sum(sum16), .carry(carry16), .busy(busy16));

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_carry;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one operand set to the 8-bit DUT and count cycles to out_valid.
   task automatic xfer8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        output int lat);
      int guard = 0;
      while (!in_ready8 && guard < 20) begin @(negedge clk); guard++; end
      a8 = ta; b8 = tb_; cin8 = tc; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0; a8 = 8'h11; b8 = 8'h11; cin8 = 1'b1;
      lat = 0;
      while (!out_valid8 && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic release8();
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
   endtask

   task automatic xfer16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input int stall, output int lat);
      int guard = 0;
      while (!in_ready16 && guard < 20) begin @(negedge clk); guard++; end
      a16 = ta; b16 = tb_; cin16 = tc; in_valid16 = 1'b1;
      @(negedge clk);
      in_valid16 = 1'b0; a16 = 16'h1111; b16 = 16'h1111; cin16 = 1'b1;
      lat = 0;
      while (!out_valid16 && lat < 40) begin @(negedge clk); lat++; end
      repeat (stall) @(negedge clk);
   endtask

   initial begin
      int lat;
      logic seen;
      logic [16:0] exp17;
      logic [15:0] ra, rb;
      logic        rc;

      tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      tbl[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

      rst_n = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst in_ready", 32'(in_ready8), 32'd0);
      chk("rst out_valid", 32'(out_valid8), 32'd0);
      chk("rst busy", 32'(busy8), 32'd0);
      chk("rst sum", 32'(sum8), 32'd0);
      chk("rst carry", 32'(carry8), 32'd0);
      chk("rst16 sum", 32'(sum16), 32'd0);
      rst_n = 1'b1;
      #1 chk("in_ready before first edge", 32'(in_ready8), 32'd0);
      @(negedge clk);
      chk("in_ready after release", 32'(in_ready8), 32'd1);
      chk("in_ready16 after release", 32'(in_ready16), 32'd1);

      // Directed table, W=8 B=1
      for (int i = 0; i < 7; i++) begin
         xfer8(tbl[i].a, tbl[i].b, tbl[i].cin, lat);
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
         chk($sformatf("vec%0d sum", i), 32'(sum8), 32'(tbl[i].exp_sum));
         chk($sformatf("vec%0d carry", i), 32'(carry8), 32'(tbl[i].exp_carry));
         chk($sformatf("vec%0d busy", i), 32'(busy8), 32'd1);
         release8();
         chk($sformatf("vec%0d out_valid drop", i), 32'(out_valid8), 32'd0);
         chk($sformatf("vec%0d in_ready back", i), 32'(in_ready8), 32'd1);
         chk($sformatf("vec%0d sum held in idle", i), 32'(sum8), 32'(tbl[i].exp_sum));
      end

      // Backpressure: 0x33 + 0x44 = 0x77 held while out_ready low
      xfer8(8'h33, 8'h44, 1'b0, lat);
      chk("bp latency", 32'(lat), 32'd8);
      for (int k = 0; k < 5; k++) begin
         in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h11; cin8 = 1'b0;
         @(negedge clk);
         in_valid8 = 1'b0;
         chk($sformatf("bp%0d sum", k), 32'(sum8), 32'h77);
         chk($sformatf("bp%0d carry", k), 32'(carry8), 32'd0);
         chk($sformatf("bp%0d in_ready", k), 32'(in_ready8), 32'd0);
         chk($sformatf("bp%0d out_valid", k), 32'(out_valid8), 32'd1);
      end
      release8();
      chk("bp out_valid drop", 32'(out_valid8), 32'd0);
      chk("bp in_ready", 32'(in_ready8), 32'd1);
      chk("bp busy", 32'(busy8), 32'd0);

      // Reset on the third RUN edge aborts the transaction
      a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      chk("abort busy", 32'(busy8), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort sum", 32'(sum8), 32'd0);
      chk("abort carry", 32'(carry8), 32'd0);
      chk("abort out_valid", 32'(out_valid8), 32'd0);
      chk("abort busy cleared", 32'(busy8), 32'd0);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid8) seen = 1'b1;
      end
      chk("abort no out_valid", 32'(seen), 32'd0);
      xfer8(8'h03, 8'h02, 1'b0, lat);
      chk("post-abort latency", 32'(lat), 32'd8);
      chk("post-abort sum", 32'(sum8), 32'h05);
      chk("post-abort carry", 32'(carry8), 32'd0);
      release8();

      // W=16 B=4 boundary
      xfer16(16'hFFFF, 16'h0001, 1'b0, 0, lat);
      chk("w16 latency", 32'(lat), 32'd4);
      chk("w16 sum", 32'(sum16), 32'h0000);
      chk("w16 carry", 32'(carry16), 32'd1);
      out_ready16 = 1'b1; @(negedge clk); out_ready16 = 1'b0;

      // Random vectors with random result stalls
      for (int v = 0; v < 1000; v++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         exp17 = 17'(ra) + 17'(rb) + 17'(rc);
         xfer16(ra, rb, rc, int'($urandom_range(0, 3)), lat);
         chk($sformatf("rnd%0d latency", v), 32'(lat), 32'd4);
         chk($sformatf("rnd%0d sum a=%h b=%h c=%b", v, ra, rb, rc), 32'(sum16), 32'(exp17[15:0]));
         chk($sformatf("rnd%0d carry", v), 32'(carry16), 32'(exp17[16]));
         out_ready16 = 1'b1; @(negedge clk); out_ready16 = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
